// File: rtl/alu_seq_pkg.sv
// Shared constants and types for the RV32I ALU source sequencer.
// Operand mux codes, opcode constants, FSM state and control-word helpers.
package alu_seq_pkg;

   localparam logic [2:0] ALU_SRC_ZERO  = 3'd0;
   localparam logic [2:0] ALU_SRC_FOUR  = 3'd1;
   localparam logic [2:0] ALU_SRC_PC    = 3'd2;
   localparam logic [2:0] ALU_SRC_REG   = 3'd3;
   localparam logic [2:0] ALU_SRC_IMM12 = 3'd4;
   localparam logic [2:0] ALU_SRC_IMM20 = 3'd5;
   localparam logic [2:0] ALU_SRC_JOFF  = 3'd6;
   localparam logic [2:0] ALU_SRC_BOFF  = 3'd7;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

   localparam logic [3:0] ALU_OP_ADD = 4'b0000;

   typedef enum logic [2:0] {
      ST_IDLE,
      ST_EXEC,
      ST_NEXT,
      ST_TARGET,
      ST_TRAP
   } seq_state_e;

   typedef struct packed {
      logic is_op;
      logic is_imm;
      logic is_lui;
      logic is_auipc;
      logic is_jal;
      logic is_jalr;
      logic is_branch;
      logic illegal;
   } dec_t;

   typedef struct packed {
      logic [2:0] src_a;
      logic [2:0] src_b;
      logic [3:0] alu_op;
      logic       rd_we;
      logic       pc_we;
      logic       trap;
      logic       ready;
   } ctl_t;

   localparam ctl_t CTL_NONE = '{ALU_SRC_ZERO, ALU_SRC_ZERO, ALU_OP_ADD, 1'b0, 1'b0, 1'b0, 1'b0};
   localparam ctl_t CTL_IDLE = '{ALU_SRC_ZERO, ALU_SRC_ZERO, ALU_OP_ADD, 1'b0, 1'b0, 1'b0, 1'b1};
   localparam ctl_t CTL_NEXT = '{ALU_SRC_PC,   ALU_SRC_FOUR, ALU_OP_ADD, 1'b0, 1'b1, 1'b0, 1'b0};
   localparam ctl_t CTL_TRAP = '{ALU_SRC_ZERO, ALU_SRC_ZERO, ALU_OP_ADD, 1'b0, 1'b0, 1'b1, 1'b0};

   // Control word for the EXEC cycle; branches and illegal opcodes drive nothing.
   function automatic ctl_t exec_ctl(input dec_t d, input logic [2:0] f3, input logic b30);
      ctl_t c;
      c = CTL_NONE;
      if (d.is_op) begin
         c.src_a  = ALU_SRC_REG;
         c.src_b  = ALU_SRC_REG;
         c.alu_op = {b30, f3};
         c.rd_we  = 1'b1;
      end else if (d.is_imm) begin
         // instr[30] is only a function bit for the right shifts
         c.src_a  = ALU_SRC_REG;
         c.src_b  = ALU_SRC_IMM12;
         c.alu_op = {(f3 == 3'b101) ? b30 : 1'b0, f3};
         c.rd_we  = 1'b1;
      end else if (d.is_lui) begin
         c.src_b  = ALU_SRC_IMM20;
         c.rd_we  = 1'b1;
      end else if (d.is_auipc) begin
         c.src_a  = ALU_SRC_PC;
         c.src_b  = ALU_SRC_IMM20;
         c.rd_we  = 1'b1;
      end else if (d.is_jal || d.is_jalr) begin
         c.src_a  = ALU_SRC_PC;
         c.src_b  = ALU_SRC_FOUR;
         c.rd_we  = 1'b1;
      end
      return c;
   endfunction

   function automatic ctl_t target_ctl(input dec_t d);
      ctl_t c;
      c = CTL_NONE;
      c.pc_we = 1'b1;
      if (d.is_jal) begin
         c.src_a = ALU_SRC_PC;
         c.src_b = ALU_SRC_JOFF;
      end else if (d.is_jalr) begin
         c.src_a = ALU_SRC_REG;
         c.src_b = ALU_SRC_IMM12;
      end else begin
         c.src_a = ALU_SRC_PC;
         c.src_b = ALU_SRC_BOFF;
      end
      return c;
   endfunction

endpackage

// File: rtl/alu_seq_decode.sv
// Combinational RV32I opcode classifier for the sequencer.
module alu_seq_decode
   import alu_seq_pkg::*;
(
   input  logic [6:0] opcode,
   output dec_t       dec
);

   always_comb begin
      dec = '0;
      case (opcode)
         OPC_OP:     dec.is_op     = 1'b1;
         OPC_OP_IMM: dec.is_imm    = 1'b1;
         OPC_LUI:    dec.is_lui    = 1'b1;
         OPC_AUIPC:  dec.is_auipc  = 1'b1;
         OPC_JAL:    dec.is_jal    = 1'b1;
         OPC_JALR:   dec.is_jalr   = 1'b1;
         OPC_BRANCH: dec.is_branch = 1'b1;
         OPC_LOAD, OPC_STORE, OPC_SYSTEM: dec.illegal = 1'b1;
         default:    dec.illegal   = 1'b1;
      endcase
   end

endmodule

// File: rtl/alu_src_sequencer.sv
// Multi-cycle RV32I control FSM driving ALU operand muxes, alu_op, PC and rd writes.
// Optional perf counters (cycles, instret) when ALU_SEQ_PERF_EN is defined.
module alu_src_sequencer
   import alu_seq_pkg::*;
#(
   parameter bit          TRAP_STICKY = 1'b1,
   parameter int unsigned CNT_W       = 32
)(
   input  logic              clk,
   input  logic              rst_n,
   input  logic              instr_valid,
   output logic              instr_ready,
   input  logic [31:0]       instr,
   input  logic              branch_taken,
   output logic [2:0]        alu_src_a,
   output logic [2:0]        alu_src_b,
   output logic [3:0]        alu_op,
   output logic [4:0]        rd_addr,
   output logic              rd_we,
   output logic              pc_we,
   output logic              trap
`ifdef ALU_SEQ_PERF_EN
   ,
   output logic [CNT_W-1:0]  cycles,
   output logic [CNT_W-1:0]  instret
`endif
);

   if (CNT_W < 1) begin : g_bad_cnt_w
      $error("CNT_W must be at least 1");
   end

   seq_state_e  state_q;
   logic [31:0] instr_q;
   ctl_t        ctl_q;
   logic [31:0] dec_word;
   dec_t        dec;
   logic        unused_bits;

   // In IDLE the word being accepted is decoded so EXEC controls are registered
   // on the accept edge; afterwards the latched word drives the decoder.
   assign dec_word = (state_q == ST_IDLE) ? instr : instr_q;

   alu_seq_decode u_decode (
      .opcode (dec_word[6:0]),
      .dec    (dec)
   );

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         instr_q <= '0;
         ctl_q   <= CTL_IDLE;
      end else begin
         case (state_q)
            ST_IDLE: begin
               if (instr_valid) begin
                  instr_q <= instr;
                  state_q <= ST_EXEC;
                  ctl_q   <= exec_ctl(dec, instr[14:12], instr[30]);
               end
            end
            ST_EXEC: begin
               if (dec.illegal) begin
                  state_q <= ST_TRAP;
                  ctl_q   <= CTL_TRAP;
               end else if (dec.is_jal || dec.is_jalr || (dec.is_branch && branch_taken)) begin
                  state_q <= ST_TARGET;
                  ctl_q   <= target_ctl(dec);
               end else begin
                  state_q <= ST_NEXT;
                  ctl_q   <= CTL_NEXT;
               end
            end
            ST_NEXT, ST_TARGET: begin
               state_q <= ST_IDLE;
               ctl_q   <= CTL_IDLE;
            end
            ST_TRAP: begin
               if (!TRAP_STICKY) begin
                  state_q <= ST_IDLE;
                  ctl_q   <= CTL_IDLE;
               end
            end
            default: begin
               state_q <= ST_IDLE;
               ctl_q   <= CTL_IDLE;
            end
         endcase
      end
   end

   assign alu_src_a   = ctl_q.src_a;
   assign alu_src_b   = ctl_q.src_b;
   assign alu_op      = ctl_q.alu_op;
   assign rd_we       = ctl_q.rd_we;
   assign pc_we       = ctl_q.pc_we;
   assign trap        = ctl_q.trap;
   assign instr_ready = ctl_q.ready;
   assign rd_addr     = instr_q[11:7];

   // Immediates are formed downstream; only opcode/rd/funct bits matter here.
   assign unused_bits = ^{instr_q[31], instr_q[29:15]};

`ifdef ALU_SEQ_PERF_EN
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cycles  <= '0;
         instret <= '0;
      end else begin
         cycles <= cycles + CNT_W'(1);
         if (state_q == ST_NEXT || state_q == ST_TARGET)
            instret <= instret + CNT_W'(1);
      end
   end
`endif

endmodule

// File: tb/tb_alu_src_sequencer.sv
// Scoreboard bench for alu_src_sequencer: per-cycle expected control words are
// queued as each instruction is driven and compared as the DUT steps.
module tb_alu_src_sequencer;

   logic        clk = 1'b0;
   logic        rst_n, instr_valid, branch_taken;
   logic [31:0] instr;
   logic        instr_ready, rd_we, pc_we, trap;
   logic [2:0]  alu_src_a, alu_src_b;
   logic [3:0]  alu_op;
   logic [4:0]  rd_addr;
   logic        ns_ready, ns_rd_we, ns_pc_we, ns_trap;
   logic [2:0]  ns_src_a, ns_src_b;
   logic [3:0]  ns_op;
   logic [4:0]  ns_rd;
`ifdef ALU_SEQ_PERF_EN
   logic [31:0] cycles, instret, ns_cycles, ns_instret;
`endif

   always #5 clk = ~clk;

   alu_src_sequencer #(.TRAP_STICKY(1'b1), .CNT_W(32)) u_dut (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
      .instr(instr), .branch_taken(branch_taken), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
      .alu_op(alu_op), .rd_addr(rd_addr), .rd_we(rd_we), .pc_we(pc_we), .trap(trap)
`ifdef ALU_SEQ_PERF_EN
      , .cycles(cycles), .instret(instret)
`endif
   );

   alu_src_sequencer #(.TRAP_STICKY(1'b0), .CNT_W(32)) u_dut_ns (
      .clk(clk), .rst_n(rst_n), .instr_valid(instr_valid), .instr_ready(ns_ready),
      .instr(instr), .branch_taken(branch_taken), .alu_src_a(ns_src_a), .alu_src_b(ns_src_b),
      .alu_op(ns_op), .rd_addr(ns_rd), .rd_we(ns_rd_we), .pc_we(ns_pc_we), .trap(ns_trap)
`ifdef ALU_SEQ_PERF_EN
      , .cycles(ns_cycles), .instret(ns_instret)
`endif
   );

   // {ready, trap, pc_we, rd_we, rd[4:0], op[3:0], b[2:0], a[2:0]}
   logic [18:0] obs;
   assign obs = {instr_ready, trap, pc_we, rd_we, rd_addr, alu_op, alu_src_b, alu_src_a};

   localparam logic [18:0] M_ALL  = 19'h7FFFF;
   localparam logic [18:0] M_NOOP = 19'h7FC3F;  // op is don't-care
   localparam logic [18:0] M_STB  = 19'h7FC00;  // strobes, ready, trap, rd only

   localparam logic [31:0] I_ADDI  = 32'h00700293;
   localparam logic [31:0] I_JAL   = 32'h010000EF;
   localparam logic [31:0] I_LW    = 32'h0000A083;

   typedef struct {
      string       tag;
      logic [18:0] v;
      logic [18:0] m;
   } exp_t;

   exp_t        sbq[$];
   int          n_vec = 0;
   int          n_err = 0;
   logic [4:0]  cur_rd;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] want);
      n_vec++;
      if (got !== want) begin
         n_err++;
         $display("FAIL %s: got %h, expected %h", tag, got, want);
      end
   endtask

   function automatic logic [18:0] pk(input logic rdy, input logic trp, input logic pcw,
                                      input logic rdw, input logic [4:0] rd,
                                      input logic [2:0] a, input logic [2:0] b,
                                      input logic [3:0] op);
      return {rdy, trp, pcw, rdw, rd, op, b, a};
   endfunction

   function automatic logic [18:0] idle_v(input logic [4:0] rd);
      return pk(1'b1, 1'b0, 1'b0, 1'b0, rd, 3'd0, 3'd0, 4'd0);
   endfunction

   task automatic exec_exp(input logic [31:0] ins, output logic [18:0] v, output logic [18:0] m);
      logic [2:0] f3;
      logic [4:0] rd;
      f3 = ins[14:12];
      rd = ins[11:7];
      m  = M_ALL;
      case (ins[6:0])
         7'b0110011: v = pk(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'd3, 3'd3, {ins[30], f3});
         7'b0010011: v = pk(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'd3, 3'd4, {(f3 == 3'b101) & ins[30], f3});
         7'b0110111: v = pk(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'd0, 3'd5, 4'd0);
         7'b0010111: v = pk(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'd2, 3'd5, 4'd0);
         7'b1101111,
         7'b1100111: v = pk(1'b0, 1'b0, 1'b0, 1'b1, rd, 3'd2, 3'd1, 4'd0);
         7'b1100011: begin v = pk(1'b0, 1'b0, 1'b0, 1'b0, rd, 3'd0, 3'd0, 4'd0); m = M_NOOP; end
         default:    begin v = pk(1'b0, 1'b0, 1'b0, 1'b0, rd, 3'd0, 3'd0, 4'd0); m = M_STB;  end
      endcase
   endtask

   function automatic logic [18:0] seq2_exp(input logic [31:0] ins, input logic tk);
      logic [4:0] rd;
      rd = ins[11:7];
      if (ins[6:0] == 7'b1101111)             return pk(1'b0, 1'b0, 1'b1, 1'b0, rd, 3'd2, 3'd6, 4'd0);
      if (ins[6:0] == 7'b1100111)             return pk(1'b0, 1'b0, 1'b1, 1'b0, rd, 3'd3, 3'd4, 4'd0);
      if (ins[6:0] == 7'b1100011 && tk)       return pk(1'b0, 1'b0, 1'b1, 1'b0, rd, 3'd2, 3'd7, 4'd0);
      return pk(1'b0, 1'b0, 1'b1, 1'b0, rd, 3'd2, 3'd1, 4'd0);
   endfunction

   task automatic push(input string tag, input logic [18:0] v, input logic [18:0] m);
      exp_t e;
      e.tag = tag;
      e.v   = v;
      e.m   = m;
      sbq.push_back(e);
   endtask

   // One clock: compare at negedge, then advance to just past the next posedge.
   task automatic step();
      exp_t e;
      @(negedge clk);
      if (sbq.size() == 0) begin
         chk("scoreboard_underflow", 32'(sbq.size()), 32'd1);
      end else begin
         e = sbq.pop_front();
         chk(e.tag, 32'(obs & e.m), 32'(e.v & e.m));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic run_instr(input logic [31:0] ins, input logic tk);
      logic [18:0] v, m;
      exec_exp(ins, v, m);
      push($sformatf("idle before %h", ins), idle_v(cur_rd), M_ALL);
      push($sformatf("exec %h", ins), v, m);
      push($sformatf("next/target %h tk=%0d", ins, tk), seq2_exp(ins, tk), M_ALL);
      instr_valid  = 1'b1;
      instr        = ins;
      branch_taken = ~tk;
      step();
      instr_valid  = 1'b0;
      instr        = $urandom();
      branch_taken = tk;
      step();
      branch_taken = ~tk;
      step();
      cur_rd = ins[11:7];
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
      $fatal(1);
   end

   initial begin
      rst_n        = 1'b0;
      instr_valid  = 1'b0;
      instr        = 32'h0;
      branch_taken = 1'b0;
      cur_rd       = 5'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      push("reset state", idle_v(5'd0), M_ALL);
      step();

`ifdef ALU_SEQ_PERF_EN
      rst_n       = 1'b1;
      instr_valid = 1'b1;
      instr       = I_ADDI;
      repeat (9) @(posedge clk);
      @(negedge clk);
      chk("perf cycles", cycles, 32'd9);
      chk("perf instret", instret, 32'd3);
      instr_valid = 1'b0;
      @(posedge clk);
      #1;
      cur_rd = 5'd5;
`else
      rst_n = 1'b1;
`endif

      run_instr(I_ADDI,       1'b0);
      run_instr(I_JAL,        1'b0);
      run_instr(32'h00208463, 1'b1);  // beq taken
      run_instr(32'h00208463, 1'b0);  // beq not taken
      run_instr(32'h402081B3, 1'b0);  // sub
      run_instr(32'h002081B3, 1'b0);  // add
      run_instr(32'h4010D093, 1'b0);  // srai
      run_instr(32'h0010D093, 1'b0);  // srli
      run_instr(32'h4070F093, 1'b0);  // andi, imm bit 30 set
      run_instr(32'h123452B7, 1'b0);  // lui
      run_instr(32'h00001317, 1'b0);  // auipc
      run_instr(32'h000080E7, 1'b0);  // jalr
      run_instr(32'h0020C663, 1'b1);  // blt taken
      push("idle after run", idle_v(cur_rd), M_ALL);
      step();

      // Reset during EXEC of a JAL: no TARGET cycle follows.
      begin
         logic [18:0] v, m;
         exec_exp(I_JAL, v, m);
         push("idle before jal/rst", idle_v(cur_rd), M_ALL);
         push("exec jal/rst", v, m);
         instr_valid = 1'b1;
         instr       = I_JAL;
         step();
         instr_valid = 1'b0;
         rst_n       = 1'b0;
         step();
         push("reset mid-op", idle_v(5'd0), M_ALL);
         step();
         rst_n  = 1'b1;
         cur_rd = 5'd0;
         push("after mid-op reset", idle_v(5'd0), M_ALL);
         step();
      end

      // LW traps; sticky copy holds, non-sticky copy returns to IDLE after one cycle.
      push("idle before lw", idle_v(cur_rd), M_ALL);
      push("exec lw", pk(1'b0, 1'b0, 1'b0, 1'b0, 5'd1, 3'd0, 3'd0, 4'd0), M_STB);
      instr_valid = 1'b1;
      instr       = I_LW;
      step();
      instr_valid = 1'b0;
      step();
      for (int i = 0; i < 10; i++) begin
         if (i == 0) chk("ns trap cycle", 32'({ns_trap, ns_ready}), 32'b10);
         if (i == 1) chk("ns back to idle", 32'({ns_trap, ns_ready}), 32'b01);
         if (i == 2) begin
            instr_valid = 1'b1;
            instr       = I_ADDI;
         end
         push($sformatf("sticky trap %0d", i), pk(1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 3'd0, 3'd0, 4'd0), M_STB);
         step();
      end
      rst_n = 1'b0;
      push("trap until reset edge", pk(1'b0, 1'b1, 1'b0, 1'b0, 5'd1, 3'd0, 3'd0, 4'd0), M_STB);
      step();
      push("reset out of trap", idle_v(5'd0), M_ALL);
      step();
      rst_n       = 1'b1;
      instr_valid = 1'b0;
      cur_rd      = 5'd0;

      run_instr(I_ADDI, 1'b0);
      push("final idle", idle_v(cur_rd), M_ALL);
      step();

      chk("scoreboard drained", 32'(sbq.size()), 32'd0);
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
